// File: rtl/emesh_arb_router_if.sv
// emesh_arb_router port bundle: N requesters, elink forward link,
// elink return link and N response ports.
interface emesh_arb_router_if #(
  parameter int N  = 3,
  parameter int PW = 103
);
  logic [N-1:0]    req_access_in;
  logic [N*PW-1:0] req_packet_in;
  logic [N-1:0]    req_wait_out;

  logic            fwd_access_out;
  logic [PW-1:0]   fwd_packet_out;
  logic            fwd_wait_in;
  logic [N-1:0]    fwd_grant_out;

  logic            ret_access_in;
  logic [PW-1:0]   ret_packet_in;
  logic            ret_wait_out;

  logic [N-1:0]    rsp_access_out;
  logic [PW-1:0]   rsp_packet_out;
  logic [N-1:0]    rsp_wait_in;

  modport slave (
    input  req_access_in, req_packet_in,
    input  fwd_wait_in,
    input  ret_access_in, ret_packet_in,
    input  rsp_wait_in,
    output req_wait_out,
    output fwd_access_out, fwd_packet_out,
    output fwd_grant_out,
    output ret_wait_out,
    output rsp_access_out, rsp_packet_out
  );

  modport master (
    output req_access_in, req_packet_in,
    output fwd_wait_in,
    output ret_access_in, ret_packet_in,
    output rsp_wait_in,
    input  req_wait_out,
    input  fwd_access_out, fwd_packet_out,
    input  fwd_grant_out,
    input  ret_wait_out,
    input  rsp_access_out, rsp_packet_out
  );
endinterface

// File: rtl/emesh_arb_router.sv
// N-port emesh arbiter onto one elink-bound output, plus a return
// router steering elink traffic to a port by dstaddr[31:20].
module emesh_arb_router #(
  parameter int N            = 3,
  parameter int PW           = 103,
  parameter int ARB_MODE     = 0,
  parameter logic [N*12-1:0] ROUTE_ID =
    {12'h810, 12'h808, 12'h000},
  parameter int DEFAULT_PORT = N - 1
) (
  input  logic eclk,
  input  logic reset,
  emesh_arb_router_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] gidx;
  logic [IW-1:0] cand;
  logic          found;
  logic          fstall;
  logic [N-1:0]  gnt;
  logic [PW-1:0] gpkt;

  assign fstall = bus.fwd_access_out & bus.fwd_wait_in;

  // first requester in search order: pointer-relative or from 0
  always_comb begin
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ARB_MODE == 1)
        cand = IW'(k);
      else
        cand = IW'((int'(ptr) + k) % N);
      if (!found && bus.req_access_in[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && !fstall)
      gnt[gidx] = 1'b1;
  end

  assign gpkt = bus.req_packet_in[int'(gidx)*PW +: PW];

  assign ptr_nxt = (gidx == IW'(N - 1)) ?
                   '0 : gidx + IW'(1);

  assign bus.req_wait_out =
    bus.req_access_in &
    ({N{reset | fstall}} | ~gnt);

  always_ff @(posedge eclk) begin
    if (reset) begin
      bus.fwd_access_out <= 1'b0;
      bus.fwd_packet_out <= '0;
      bus.fwd_grant_out  <= '0;
      ptr                <= '0;
    end else if (!fstall) begin
      bus.fwd_access_out <= found;
      bus.fwd_grant_out  <= gnt;
      if (found)
        bus.fwd_packet_out <= gpkt;
      if (found && ARB_MODE == 0)
        ptr <= ptr_nxt;
    end
  end

  logic [IW-1:0] sel;
  logic          hit;
  logic [N-1:0]  sel_oh;
  logic          rstall;

  // lowest matching coordinate wins; no match goes to DEFAULT_PORT
  always_comb begin
    sel = IW'(DEFAULT_PORT);
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit &&
          ROUTE_ID[12*i +: 12] == bus.ret_packet_in[95:84]) begin
        hit = 1'b1;
        sel = IW'(i);
      end
    end
  end

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  assign rstall = |(bus.rsp_access_out & bus.rsp_wait_in);

  assign bus.ret_wait_out =
    bus.ret_access_in & (reset | rstall);

  always_ff @(posedge eclk) begin
    if (reset) begin
      bus.rsp_access_out <= '0;
      bus.rsp_packet_out <= '0;
    end else if (!rstall) begin
      bus.rsp_access_out <=
        bus.ret_access_in ? sel_oh : '0;
      if (bus.ret_access_in)
        bus.rsp_packet_out <= bus.ret_packet_in;
    end
  end

endmodule

// File: tb/tb_emesh_arb_router.sv
// Scoreboard bench: round-robin and fixed-priority instances share
// stimulus; a transaction-level model predicts every delivered beat.
module tb_emesh_arb_router;
  localparam int N  = 3;
  localparam int PW = 103;
  localparam logic [35:0] RID = {12'h810, 12'h808, 12'h000};

  logic eclk = 1'b0;
  logic reset = 1'b1;
  always #5 eclk = ~eclk;

  emesh_arb_router_if #(.N(N), .PW(PW)) b0 ();
  emesh_arb_router_if #(.N(N), .PW(PW)) b1 ();

  emesh_arb_router #(
    .N(N), .PW(PW), .ARB_MODE(0),
    .ROUTE_ID(RID), .DEFAULT_PORT(N-1)
  ) dut0 (.eclk(eclk), .reset(reset), .bus(b0.slave));

  emesh_arb_router #(
    .N(N), .PW(PW), .ARB_MODE(1),
    .ROUTE_ID(RID), .DEFAULT_PORT(N-1)
  ) dut1 (.eclk(eclk), .reset(reset), .bus(b1.slave));

  assign b1.req_access_in = b0.req_access_in;
  assign b1.req_packet_in = b0.req_packet_in;
  assign b1.fwd_wait_in   = b0.fwd_wait_in;
  assign b1.ret_access_in = b0.ret_access_in;
  assign b1.ret_packet_in = b0.ret_packet_in;
  assign b1.rsp_wait_in   = b0.rsp_wait_in;

  typedef struct {
    logic [PW-1:0] pkt;
    logic [N-1:0]  port;
  } exp_t;

  exp_t fq0[$];
  exp_t fq1[$];
  exp_t rq[$];

  int tests = 0;
  int fails = 0;

  // model state: is a beat held at the output, and whose turn is next
  bit           fv[2];
  int           ptr[2];
  logic [N-1:0] rv;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int route(input logic [11:0] id);
    int tbl[N];
    for (int i = 0; i < N; i++) tbl[i] = int'(RID[12*i +: 12]);
    foreach (tbl[i]) if (tbl[i] == int'(id)) return i;
    return N - 1;
  endfunction

  function automatic logic [PW-1:0] mkpkt(input logic [11:0] id,
                                          input logic [31:0] data);
    logic [127:0] r;
    logic [PW-1:0] p;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    p = r[PW-1:0];
    p[95:84] = id;
    p[31:0] = data;
    return p;
  endfunction

  task automatic step(input logic [N-1:0] acc,
                      input logic [N*PW-1:0] pk,
                      input logic fw,
                      input logic racc,
                      input logic [PW-1:0] rp,
                      input logic [N-1:0] rw);
    @(posedge eclk);
    #1;
    reset = 1'b0;
    b0.req_access_in = acc;
    b0.req_packet_in = pk;
    b0.fwd_wait_in   = fw;
    b0.ret_access_in = racc;
    b0.ret_packet_in = rp;
    b0.rsp_wait_in   = rw;
    #1;
    for (int m = 0; m < 2; m++) begin
      bit st;
      int w;
      logic [N-1:0] ew;
      exp_t e;
      st = fv[m] && fw;
      w = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m == 1) ? k : (ptr[m] + k) % N;
        if (w < 0 && acc[j]) w = j;
      end
      for (int i = 0; i < N; i++)
        ew[i] = acc[i] && (st || w != i);
      chk(m == 0 ? "req_wait_rr" : "req_wait_fx",
          128'(m == 0 ? b0.req_wait_out : b1.req_wait_out),
          128'(ew));
      if (!st) begin
        if (w >= 0) begin
          e.pkt  = pk[w*PW +: PW];
          e.port = N'(1 << w);
          if (m == 0) fq0.push_back(e);
          else        fq1.push_back(e);
          fv[m] = 1;
          if (m == 0) ptr[m] = (w + 1) % N;
        end else begin
          fv[m] = 0;
        end
      end
    end
    begin
      bit st;
      exp_t e;
      st = |(rv & rw);
      chk("ret_wait", 128'(b0.ret_wait_out), 128'(racc & st));
      if (!st) begin
        if (racc) begin
          e.pkt  = rp;
          e.port = N'(1 << route(rp[95:84]));
          rq.push_back(e);
          rv = e.port;
        end else begin
          rv = '0;
        end
      end
    end
  endtask

  // a beat is consumed when valid is presented with no stall
  always @(negedge eclk) begin
    exp_t e;
    if (!reset) begin
      if (b0.fwd_access_out === 1'b1 && b0.fwd_wait_in === 1'b0) begin
        if (fq0.size() == 0) begin
          chk("fwd_rr_unexpected", 128'(b0.fwd_grant_out), 128'(0));
        end else begin
          e = fq0.pop_front();
          chk("fwd_rr_pkt", 128'(b0.fwd_packet_out), 128'(e.pkt));
          chk("fwd_rr_grant", 128'(b0.fwd_grant_out), 128'(e.port));
        end
      end
      if (b1.fwd_access_out === 1'b1 && b1.fwd_wait_in === 1'b0) begin
        if (fq1.size() == 0) begin
          chk("fwd_fx_unexpected", 128'(b1.fwd_grant_out), 128'(0));
        end else begin
          e = fq1.pop_front();
          chk("fwd_fx_pkt", 128'(b1.fwd_packet_out), 128'(e.pkt));
          chk("fwd_fx_grant", 128'(b1.fwd_grant_out), 128'(e.port));
        end
      end
      if (b0.rsp_access_out !== '0 &&
          !(|(b0.rsp_access_out & b0.rsp_wait_in))) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 128'(b0.rsp_access_out), 128'(0));
        end else begin
          e = rq.pop_front();
          chk("rsp_pkt", 128'(b0.rsp_packet_out), 128'(e.pkt));
          chk("rsp_port", 128'(b0.rsp_access_out), 128'(e.port));
        end
      end
    end
  end

  logic [N*PW-1:0] pk;
  logic [PW-1:0]   rp;

  initial begin
    fv[0] = 0; fv[1] = 0;
    ptr[0] = 0; ptr[1] = 0;
    rv = '0;
    b0.req_access_in = 3'b111;
    b0.req_packet_in = '0;
    b0.fwd_wait_in   = 1'b0;
    b0.ret_access_in = 1'b1;
    b0.ret_packet_in = '0;
    b0.rsp_wait_in   = '0;

    repeat (2) @(posedge eclk);
    #1;
    chk("rst_fwd_access", 128'(b0.fwd_access_out), 128'(0));
    chk("rst_fwd_packet", 128'(b0.fwd_packet_out), 128'(0));
    chk("rst_fwd_grant", 128'(b0.fwd_grant_out), 128'(0));
    chk("rst_fx_grant", 128'(b1.fwd_grant_out), 128'(0));
    chk("rst_rsp_access", 128'(b0.rsp_access_out), 128'(0));
    chk("rst_rsp_packet", 128'(b0.rsp_packet_out), 128'(0));
    chk("rst_req_wait", 128'(b0.req_wait_out), 128'(3'b111));
    chk("rst_ret_wait", 128'(b0.ret_wait_out), 128'(1));

    // all three requesting: rotation A0,B1,C2
    pk = {mkpkt(12'h0, 32'hC2), mkpkt(12'h0, 32'hB1),
          mkpkt(12'h0, 32'hA0)};
    repeat (6) step(3'b111, pk, 1'b0, 1'b0, '0, '0);

    // fixed priority: port 0 joins at the third cycle
    repeat (2) step(3'b110, pk, 1'b0, 1'b0, '0, '0);
    repeat (4) step(3'b111, pk, 1'b0, 1'b0, '0, '0);

    // hold a 0x1234 beat under downstream stall for 4 cycles
    pk = {mkpkt(12'h0, 32'h1234), mkpkt(12'h0, 32'h1234),
          mkpkt(12'h0, 32'h1234)};
    step(3'b111, pk, 1'b0, 1'b0, '0, '0);
    repeat (4) step(3'b111, pk, 1'b1, 1'b0, '0, '0);
    repeat (2) step(3'b111, pk, 1'b0, 1'b0, '0, '0);
    step(3'b000, pk, 1'b0, 1'b0, '0, '0);

    // return routing: exact, exact, default
    step('0, pk, 1'b0, 1'b1, mkpkt(12'h810, 32'h1), '0);
    step('0, pk, 1'b0, 1'b1, mkpkt(12'h808, 32'h2), '0);
    step('0, pk, 1'b0, 1'b1, mkpkt(12'h123, 32'h3), '0);
    step('0, pk, 1'b0, 1'b1, mkpkt(12'h808, 32'h4), '0);
    // targeted port stalls, then an unrelated port's wait is ignored
    rp = mkpkt(12'h000, 32'h5);
    step('0, pk, 1'b0, 1'b1, rp, 3'b010);
    step('0, pk, 1'b0, 1'b1, rp, 3'b010);
    step('0, pk, 1'b0, 1'b1, rp, 3'b100);
    step('0, pk, 1'b0, 1'b0, '0, '0);

    for (int c = 0; c < 3000; c++) begin
      logic [11:0] id;
      for (int i = 0; i < N; i++)
        pk[i*PW +: PW] = mkpkt(12'(i), $urandom());
      case ($urandom_range(0, 3))
        0: id = 12'h810;
        1: id = 12'h808;
        2: id = 12'h000;
        default: id = 12'($urandom());
      endcase
      step(3'($urandom()), pk,
           $urandom_range(0, 2) == 0,
           1'($urandom()),
           mkpkt(id, $urandom()),
           3'($urandom() & $urandom()));
    end

    repeat (4) step('0, pk, 1'b0, 1'b0, '0, '0);
    @(posedge eclk);
    #1;
    chk("drain_fwd_rr", 128'(fq0.size()), 128'(0));
    chk("drain_fwd_fx", 128'(fq1.size()), 128'(0));
    chk("drain_rsp", 128'(rq.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/emesh_arb_router.md
Name: emesh_arb_router

Overview:
- Parametrised successor to the two-port AXI/elink interface.
- Forward path: arbitrates N emesh requesters onto one registered elink-bound output, using either round-robin or fixed priority in place of the old fixed toggle.
- Return path: routes one elink-sourced transaction stream to one of N ports by matching dstaddr[31:20] against a per-port coordinate table.
- Both directions are registered (1-cycle latency) and use emesh wait backpressure.

Parameters:
- N, 3, number of requester/return ports (2..8).
- PW, 103, packet width: [102] write, [101:100] datamode, [99:96] ctrlmode, [95:64] dstaddr, [63:32] srcaddr, [31:0] data.
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with port 0 highest.
- ROUTE_ID, {12'h810,12'h808,12'h000}, packed N×12 coordinates; port i uses ROUTE_ID[12i+11:12i].
- DEFAULT_PORT, N-1, return port used when no ROUTE_ID entry matches.

Ports:
- eclk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_access_in  in  N  per-port request valid.
- req_packet_in  in  N*PW  per-port packet; port i at [PW*i+PW-1:PW*i].
- req_wait_out  out  N  per-port stall; the requester holds its packet while this is high.
- fwd_access_out  out  1  registered forward valid.
- fwd_packet_out  out  PW  registered forward packet.
- fwd_wait_in  in  1  downstream stall.
- fwd_grant_out  out  N  one-hot, registered; the port that sourced the current fwd_* packet.
- ret_access_in  in  1  return valid.
- ret_packet_in  in  PW  return packet.
- ret_wait_out  out  1  return-path stall.
- rsp_access_out  out  N  registered one-hot return valid.
- rsp_packet_out  out  PW  registered return packet, shared by all ports.
- rsp_wait_in  in  N  per-port return stall.

Behaviour:
- Reset values (on the first eclk edge with reset=1): fwd_access_out=0, fwd_packet_out=0, fwd_grant_out=0, rsp_access_out=0, rsp_packet_out=0, RR pointer=0.
- During reset: req_wait_out=req_access_in and ret_wait_out=ret_access_in, so nothing is accepted. Any in-flight registered transaction is dropped.

Forward path:
- fstall = fwd_access_out & fwd_wait_in.
- The combinational grant g is chosen among req_access_in, and is only valid when !fstall:
  - RR mode: search starts at the pointer and wraps N-1→0.
  - Fixed mode: lowest index wins.
- req_wait_out[i] = req_access_in[i] & (fstall | ~g[i]).
- Acceptance occurs when g is non-zero and !fstall. At the next edge: fwd_access_out=1, fwd_packet_out=packet of the granted port, fwd_grant_out=g, and in RR mode pointer=(granted index+1) mod N.
- If !fstall and no request is present, fwd_access_out←0 and the packet register holds its old value.
- If fstall, all fwd_* registers hold and the pointer holds.
- Throughput is one transaction per cycle when fwd_wait_in=0. Latency from acceptance to fwd_access_out is 1 cycle.
- Wait is combinational in the same cycle (emesh convention). There is no skid buffer: a fwd_wait_in asserted during a cycle blocks acceptance in that same cycle.

Return path:
- sel = the index i with ROUTE_ID[i]==ret_packet_in[95:84]; the lowest i wins on a duplicate match; DEFAULT_PORT if nothing matches.
- rstall = |(rsp_access_out & rsp_wait_in). Only the currently targeted port's wait matters.
- ret_wait_out = ret_access_in & rstall.
- If ret_access_in & !rstall, then at the next edge: rsp_access_out=onehot(sel) and rsp_packet_out=ret_packet_in.
- If !ret_access_in & !rstall, rsp_access_out←0.
- If rstall, the rsp registers hold.
- The forward and return paths are fully independent and may both transfer in the same cycle.

Boundary rules:
- All N ports requesting continuously in RR mode: grants rotate 0,1,…,N-1,0. No port waits more than N-1 accepted transactions.
- A stall released in cycle t allows acceptance in cycle t itself, because fstall is evaluated combinationally from that cycle's fwd_wait_in.
- A requester that drops access while waiting: legal; no state is retained.

Test Plan:
- Reset with all req_access_in=3'b111 → all outputs 0, req_wait_out=3'b111. First cycle after reset: grant port 0, and fwd_grant_out=3'b001 the next cycle.
- RR mode, N=3, all three requesting with data 0xA0/0xB1/0xC2 held for 6 cycles → fwd data sequence A0,B1,C2,A0,B1,C2 on consecutive cycles.
- ARB_MODE=1, ports 1 and 2 requesting, port 0 joins at cycle 3 → port 0 granted at cycle 3; port 2 is starved while port 1 requests.
- fwd_wait_in=1 for 4 cycles while fwd_access_out=1 with data 0x1234 → packet stable for 4 cycles, req_wait_out=3'b111, pointer unchanged; next grant is the expected RR successor.
- Return dstaddr 0x81000000 → rsp_access_out=3'b100. dstaddr 0x80800000 → 3'b010. dstaddr 0x12300000 → 3'b100 (DEFAULT_PORT).
- rsp_access_out=3'b010 with rsp_wait_in=3'b010 and a new return pending → ret_wait_out=1, registers hold. rsp_wait_in=3'b100 alone → no stall, and the new packet is delivered next cycle.
